// File: rtl/risc_constants.sv
// rtl/risc_constants.sv - shared fetch constants, address widths and FSM state encoding
package risc_constants;

  localparam int XADR = 32;
  localparam int ILEN = 32;
  localparam int IMEM_WORDS_DEF = 128;
  localparam logic [XADR-1:0] RESET_ADDR_DEF = 32'd0;
  localparam logic [XADR-1:0] ILLOP_ADDR_DEF = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  function automatic logic [XADR-1:0] word_align(input logic [XADR-1:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - next-PC selection: redirect, +4, illop vector (FETCH_BOUNDS_CHECK_EN) or hold
module fetch_pc_gen
  import risc_constants::*;
#(
  parameter logic [XADR-1:0] ILLOP_ADDR = ILLOP_ADDR_DEF,
  parameter int IMEM_WORDS = IMEM_WORDS_DEF
) (
  input  logic [XADR-1:0] pc_q,
  input  logic            redirect_en,
  input  logic [XADR-1:0] redirect_target,
  input  logic            fetch_en,
  output logic [XADR-1:0] pc_next
`ifdef FETCH_BOUNDS_CHECK_EN
  ,output logic           oob
`endif
);

`ifdef FETCH_BOUNDS_CHECK_EN
  logic out_of_range;
  assign out_of_range = (pc_q >> 2) >= 32'(IMEM_WORDS);
  assign oob = fetch_en && !redirect_en && out_of_range;
`endif

  always_comb begin
    pc_next = pc_q;
    if (redirect_en) begin
      pc_next = word_align(redirect_target);
    end else if (fetch_en) begin
`ifdef FETCH_BOUNDS_CHECK_EN
      pc_next = out_of_range ? ILLOP_ADDR : pc_q + 32'd4;
`else
      pc_next = pc_q + 32'd4;
`endif
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, IF/ID register, halt FSM; FETCH_BOUNDS_CHECK_EN adds illop
module instr_fetch
  import risc_constants::*;
#(
  parameter logic [XADR-1:0] RESET_ADDR = RESET_ADDR_DEF,
  parameter int IMEM_WORDS = IMEM_WORDS_DEF,
  parameter logic [XADR-1:0] ILLOP_ADDR = ILLOP_ADDR_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XADR-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_data,
  output logic            if_valid,
  output logic [ILEN-1:0] if_instr,
  output logic [XADR-1:0] if_pc,
  output logic [XADR-1:0] if_pc_plus4,
  input  logic            id_ready,
  input  logic            redirect_valid,
  input  logic [XADR-1:0] redirect_target,
  input  logic            halt_req,
  input  logic            resume,
  output logic            halted,
  output logic [15:0]     fetch_count
`ifdef FETCH_BOUNDS_CHECK_EN
  ,output logic           illop
`endif
);

  fetch_state_e    state_q;
  logic [XADR-1:0] pc_q;
  logic [XADR-1:0] pc_next;
  logic            redirect_en;
  logic            load;
  logic            fetch_en;
  logic            xfer;
  logic            oob;

  assign imem_addr   = pc_q;
  assign redirect_en = redirect_valid && (state_q != ST_BOOT);
  assign load        = !if_valid || id_ready;
  assign fetch_en    = (state_q == ST_RUN) && load && !redirect_en;
  // A squashed instruction is discarded, not handed to decode.
  assign xfer        = if_valid && id_ready && !redirect_en;

  fetch_pc_gen #(
    .ILLOP_ADDR(ILLOP_ADDR),
    .IMEM_WORDS(IMEM_WORDS)
  ) u_pc_gen (
    .pc_q           (pc_q),
    .redirect_en    (redirect_en),
    .redirect_target(redirect_target),
    .fetch_en       (fetch_en),
    .pc_next        (pc_next)
`ifdef FETCH_BOUNDS_CHECK_EN
    ,.oob           (oob)
`endif
  );

`ifndef FETCH_BOUNDS_CHECK_EN
  assign oob = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_ADDR;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
      halted      <= 1'b0;
      fetch_count <= '0;
`ifdef FETCH_BOUNDS_CHECK_EN
      illop       <= 1'b0;
`endif
    end else begin
      pc_q <= pc_next;
      if (xfer) fetch_count <= fetch_count + 16'd1;

      if (redirect_en) begin
        if_valid <= 1'b0;
      end else if (fetch_en && !oob) begin
        if_valid    <= 1'b1;
        if_instr    <= imem_data;
        if_pc       <= pc_q;
        if_pc_plus4 <= pc_q + 32'd4;
      end else if (fetch_en || xfer) begin
        if_valid <= 1'b0;
      end

`ifdef FETCH_BOUNDS_CHECK_EN
      illop <= fetch_en && oob;
`endif

      case (state_q)
        ST_BOOT: begin
          state_q <= ST_RUN;
          halted  <= 1'b0;
        end
        ST_RUN: begin
          if (halt_req) begin
            state_q <= ST_HALT;
            halted  <= 1'b1;
          end
        end
        ST_HALT: begin
          if (resume && !halt_req) begin
            state_q <= ST_RUN;
            halted  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_BOOT;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch against a behavioural fetch model
module tb_instr_fetch;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  localparam logic [31:0] ROM_KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_data;
  logic        if_valid;
  logic [31:0] if_instr, if_pc, if_pc_plus4;
  logic        id_ready, redirect_valid, halt_req, resume, halted;
  logic [31:0] redirect_target;
  logic [15:0] fetch_count;
`ifdef FETCH_BOUNDS_CHECK_EN
  logic        illop;
`endif

  always #5 clk = ~clk;
  assign imem_data = imem_addr ^ ROM_KEY;

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halt_req       (halt_req),
    .resume         (resume),
    .halted         (halted),
    .fetch_count    (fetch_count)
`ifdef FETCH_BOUNDS_CHECK_EN
    ,.illop         (illop)
`endif
  );

  int total = 0;
  int bad = 0;

  logic [31:0] m_pc, m_ipc, m_ip4, m_instr;
  logic [15:0] m_cnt;
  bit          m_valid, m_illop;
  int          m_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_ipc = 32'd0; m_ip4 = 32'd0; m_instr = 32'd0;
    m_cnt = 16'd0; m_valid = 1'b0; m_illop = 1'b0; m_mode = M_BOOT;
  endtask

  // One clock edge of the fetch rules, from the inputs currently applied.
  task automatic model_step();
    bit redir, xfer;
    redir = redirect_valid && (m_mode != M_BOOT);
    xfer  = m_valid && id_ready && !redir;
    m_illop = 1'b0;
    if (xfer) m_cnt = m_cnt + 16'd1;
    if (redir) begin
      m_pc = {redirect_target[31:2], 2'b00};
      m_valid = 1'b0;
    end else if (m_mode == M_RUN && (!m_valid || id_ready)) begin
`ifdef FETCH_BOUNDS_CHECK_EN
      if (m_pc / 4 >= 128) begin
        m_illop = 1'b1; m_pc = 32'd4; m_valid = 1'b0;
      end else
`endif
      begin
        m_ipc = m_pc; m_ip4 = m_pc + 32'd4; m_instr = m_pc ^ ROM_KEY;
        m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end
    end else if (xfer) begin
      m_valid = 1'b0;
    end
    if (m_mode == M_BOOT) m_mode = M_RUN;
    else if (m_mode == M_RUN && halt_req) m_mode = M_HALT;
    else if (m_mode == M_HALT && resume && !halt_req) m_mode = M_RUN;
  endtask

  task automatic check_all();
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
    chk("if_pc", if_pc, m_ipc);
    chk("if_pc_plus4", if_pc_plus4, m_ip4);
    chk("if_instr", if_instr, m_instr);
    chk("fetch_count", {16'd0, fetch_count}, {16'd0, m_cnt});
    chk("halted", {31'd0, halted}, {31'd0, m_mode == M_HALT});
`ifdef FETCH_BOUNDS_CHECK_EN
    chk("illop", {31'd0, illop}, {31'd0, m_illop});
`endif
  endtask

  task automatic step(input bit rdy, input bit rv, input logic [31:0] tgt, input bit hr, input bit rs);
    id_ready = rdy; redirect_valid = rv; redirect_target = tgt; halt_req = hr; resume = rs;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b1;
    id_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 32'd0;
    halt_req = 1'b0; resume = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk) rst_n = 1'b1;

    // Boot cycle then sustained fetch of 0, 4, 8
    step(1, 0, 0, 0, 0);
    chk("boot_no_fetch", imem_addr, 32'd0);
    repeat (3) step(1, 0, 0, 0, 0);
    chk("seq_if_pc", if_pc, 32'd8);
    // Backpressure holds the instruction at 8
    repeat (3) begin
      step(0, 0, 0, 0, 0);
      chk("stall_if_pc", if_pc, 32'd8);
      chk("stall_addr", imem_addr, 32'd12);
    end
    step(1, 0, 0, 0, 0);
    chk("release_if_pc", if_pc, 32'd12);
    chk("release_count", {16'd0, fetch_count}, 32'd3);

    // Redirect during a stall squashes without counting
    step(0, 1, 32'h53, 0, 0);
    chk("redir_addr", imem_addr, 32'h50);
    chk("redir_squash", {31'd0, if_valid}, 32'd0);
    chk("redir_count", {16'd0, fetch_count}, 32'd3);
    step(1, 0, 0, 0, 0);
    chk("redir_if_pc", if_pc, 32'h50);

    // Halt at 16, halt+resume stays halted, resume alone restarts at 20
    step(1, 1, 32'h10, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("halt_fetched", if_pc, 32'h10);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    step(1, 0, 0, 1, 1);
    chk("halt_wins", {31'd0, halted}, 32'd1);
    chk("halt_addr", imem_addr, 32'd20);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    chk("resume_if_pc", if_pc, 32'd20);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 32'h1FF),
           $urandom_range(0, 14) == 0, $urandom_range(0, 4) == 0);
    end

    // Asynchronous reset in the middle of a cycle
    step(1, 1, 32'h40, 0, 1);
    step(1, 0, 0, 0, 0);
    chk("pre_reset_valid", {31'd0, if_valid}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_valid", {31'd0, if_valid}, 32'd0);
    chk("async_addr", imem_addr, 32'd0);
    chk("async_count", {16'd0, fetch_count}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step(1, 1, 32'h80, 0, 0);
    chk("boot_redirect_ignored", imem_addr, 32'd0);

`ifdef FETCH_BOUNDS_CHECK_EN
    step(1, 1, 32'h200, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("oob_illop", {31'd0, illop}, 32'd1);
    chk("oob_addr", imem_addr, 32'd4);
    chk("oob_valid", {31'd0, if_valid}, 32'd0);
    step(1, 0, 0, 0, 0);
    chk("oob_pulse_once", {31'd0, illop}, 32'd0);
    step(1, 1, 32'h1FC, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("edge_if_pc", if_pc, 32'h1FC);
    chk("edge_valid", {31'd0, if_valid}, 32'd1);
`else
    step(1, 1, 32'hFFFF_FFFF, 0, 0);
    chk("wrap_target", imem_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'd0);
    chk("wrap_plus4", if_pc_plus4, 32'd0);
`endif
    repeat (20) step($urandom_range(0, 1) != 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
